// File: rtl/spi_frame_ctrl_if.sv
// ============================================================================
// spi_frame_ctrl_if : SPI pin and register-bank bundle for spi_frame_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

interface spi_frame_ctrl_if;
  logic       SCLK;
  logic       COPI;
  logic       nCS;
  logic [7:0] data0;
  logic [7:0] data1;
  logic [7:0] data2;
  logic [7:0] data3;
  logic [7:0] data4;
  logic       wr_strobe;
  logic [2:0] wr_addr;
  logic       frame_err;

  modport master (
    output SCLK, COPI, nCS,
    input  data0, data1, data2, data3, data4, wr_strobe, wr_addr, frame_err
  );

  modport slave (
    input  SCLK, COPI, nCS,
    output data0, data1, data2, data3, data4, wr_strobe, wr_addr, frame_err
  );
endinterface

`default_nettype wire

// File: rtl/spi_frame_ctrl.sv
// ============================================================================
// spi_frame_ctrl : clk-domain SPI write framer committing to a 5-entry reg bank
// Rev 1.0
// ============================================================================
`default_nettype none

module spi_frame_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_ADDR    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_frame_ctrl_if.slave  bus
);

  localparam logic [6:0] MAX_A   = 7'(MAX_ADDR);
  localparam logic [4:0] CNT_OVF = 5'd17;
  localparam logic [4:0] CNT_OK  = 5'd16;

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] copi_sync;
  logic [SYNC_STAGES-1:0] ncs_sync;
  logic                   sclk_d;
  logic                   ncs_d;
  logic [SYNC_STAGES:0]   warm_sr;

  state_t      state;
  logic [15:0] shreg;
  logic [4:0]  bitcnt;
  logic [7:0]  regs [5];
  logic        wr_strobe;
  logic        frame_err;
  logic [2:0]  wr_addr;

  logic sclk_s, copi_s, ncs_s, warm;
  logic sclk_rise, ncs_fall, ncs_rise;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign copi_s = copi_sync[SYNC_STAGES-1];
  assign ncs_s  = ncs_sync[SYNC_STAGES-1];
  assign warm   = warm_sr[SYNC_STAGES];

  // Edges are masked until the chains hold real pin samples, so an nCS held
  // low across reset release is not mistaken for a new frame start.
  assign sclk_rise = sclk_s & ~sclk_d;
  assign ncs_fall  = warm & ncs_d & ~ncs_s;
  assign ncs_rise  = warm & ~ncs_d & ncs_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      copi_sync <= '0;
      ncs_sync  <= '1;
      sclk_d    <= 1'b0;
      ncs_d     <= 1'b1;
      warm_sr   <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.SCLK};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], bus.COPI};
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], bus.nCS};
      sclk_d    <= sclk_s;
      ncs_d     <= ncs_s;
      warm_sr   <= {warm_sr[SYNC_STAGES-1:0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shreg     <= '0;
      bitcnt    <= '0;
      wr_strobe <= 1'b0;
      frame_err <= 1'b0;
      wr_addr   <= '0;
      for (int i = 0; i < 5; i++) regs[i] <= '0;
    end else begin
      wr_strobe <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (ncs_fall) begin
            state  <= SHIFT;
            shreg  <= '0;
            bitcnt <= '0;
          end
        end
        SHIFT: begin
          // ncs_rise implies synced nCS is high, so a coincident SCLK edge is dropped
          if (ncs_rise) begin
            state <= CHECK;
          end else if (sclk_rise && !ncs_s) begin
            shreg <= {shreg[14:0], copi_s};
            if (bitcnt != CNT_OVF) bitcnt <= bitcnt + 5'd1;
          end
        end
        CHECK: begin
          state <= IDLE;
          if (bitcnt != CNT_OK) begin
            frame_err <= 1'b1;
          end else if (shreg[15]) begin
            if (shreg[14:8] <= MAX_A) begin
              for (int i = 0; i < 5; i++)
                if (shreg[10:8] == 3'(i)) regs[i] <= shreg[7:0];
              wr_strobe <= 1'b1;
              wr_addr   <= shreg[10:8];
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.data0     = regs[0];
  assign bus.data1     = regs[1];
  assign bus.data2     = regs[2];
  assign bus.data3     = regs[3];
  assign bus.data4     = regs[4];
  assign bus.wr_strobe = wr_strobe;
  assign bus.wr_addr   = wr_addr;
  assign bus.frame_err = frame_err;

endmodule

`default_nettype wire
